// File: rtl/axi2apb_pkg.sv
// Shared constants for the AXI-to-APB request scheduler: bus widths,
// response codes and FSM state encodings.
package axi2apb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PADDR_W = 16;
  localparam int unsigned DATA_W  = 32;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/axi2apb_sched_if.sv
// Request/response and APB signal bundle for axi2apb_sched.
// master = scheduler view, slave = requester plus APB target view.
interface axi2apb_sched_if;
  import axi2apb_pkg::*;

  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_req;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               rd_gnt;
  logic               wr_gnt;
  logic               rd_done;
  logic [DATA_W-1:0]  rd_data;
  logic [1:0]         rd_resp;
  logic               wr_done;
  logic [1:0]         wr_resp;
  logic [PADDR_W-1:0] PADDR;
  logic               PWRITE;
  logic               PSEL;
  logic               PENABLE;
  logic [DATA_W-1:0]  PWDATA;
  logic [DATA_W-1:0]  PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, PRDATA, PREADY, PSLVERR,
    output rd_gnt, wr_gnt, rd_done, rd_data, rd_resp, wr_done, wr_resp,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, PRDATA, PREADY, PSLVERR,
    input  rd_gnt, wr_gnt, rd_done, rd_data, rd_resp, wr_done, wr_resp,
           PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

endinterface

// File: rtl/axi2apb_wdt.sv
// ACCESS-phase wait counter: counts stalled cycles and flags the last
// permitted one so the scheduler can force termination.
module axi2apb_wdt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi2apb_sched.sv
// Arbitrates single read/write requests onto an APB master port with
// address decode, wait-state timeout and read-streak write fairness.
module axi2apb_sched
  import axi2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned RD_STREAK = 4,
  parameter logic [3:0]  DEC_NIB   = 4'hA
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi2apb_sched_if.master bus
);

  localparam int unsigned SW = $clog2(RD_STREAK + 1);

  logic [1:0]         state_q, state_d;
  logic               dir_q, dir_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         resp_q, resp_d;
  logic [SW-1:0]      streak_q, streak_d;

  logic              idle, pick_wr, take_rd, take_wr, hit, expired, psel;
  logic [ADDR_W-1:0] req_addr;
  logic              unused_addr_bits;

  // Grants are combinational in IDLE so the transfer enters SETUP on the next edge.
  assign idle     = (state_q == ST_IDLE) && ARESETn;
  assign pick_wr  = bus.wr_req && (!bus.rd_req || (streak_q == SW'(RD_STREAK)));
  assign take_wr  = idle && pick_wr;
  assign take_rd  = idle && bus.rd_req && !pick_wr;
  assign req_addr = pick_wr ? bus.wr_addr : bus.rd_addr;
  assign hit      = (req_addr[ADDR_W-1 -: 4] == DEC_NIB);
  assign unused_addr_bits = ^req_addr[ADDR_W-5:PADDR_W];

  axi2apb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .clear_i   (state_q != ST_ACCESS),
    .enable_i  ((state_q == ST_ACCESS) && !bus.PREADY),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    paddr_d  = paddr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (take_rd || take_wr) begin
          dir_d   = take_wr;
          paddr_d = req_addr[PADDR_W-1:0];
          wdata_d = take_wr ? bus.wr_data : '0;
          rdata_d = '0;
          if (hit) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
            resp_d  = DECERR;
          end
          if (take_wr || !bus.wr_req) begin
            streak_d = '0;
          end else if (streak_q != SW'(RD_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.PREADY) begin
          rdata_d = dir_q ? '0 : bus.PRDATA;
          resp_d  = bus.PSLVERR ? SLVERR : OKAY;
          state_d = ST_RESP;
        end else if (expired) begin
          resp_d  = SLVERR;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      paddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= OKAY;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      paddr_q  <= paddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      streak_q <= streak_d;
    end
  end

  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.PSEL    = psel;
  assign bus.PENABLE = (state_q == ST_ACCESS);
  assign bus.PWRITE  = psel && dir_q;
  assign bus.PADDR   = psel ? paddr_q : '0;
  assign bus.PWDATA  = (psel && dir_q) ? wdata_q : '0;
  assign bus.rd_gnt  = take_rd;
  assign bus.wr_gnt  = take_wr;
  assign bus.rd_done = ARESETn && (state_q == ST_RESP) && !dir_q;
  assign bus.wr_done = ARESETn && (state_q == ST_RESP) && dir_q;
  assign bus.rd_data = rdata_q;
  assign bus.rd_resp = resp_q;
  assign bus.wr_resp = resp_q;

endmodule
